// File: rtl/io_bus_sel_ctrl.sv
// IO access sequencer: decodes the core address into a one-hot slave select,
// drives strobes and bus_sel, waits for ready with timeout and returns one response.
module io_bus_sel_ctrl #(
    parameter int                    NR_OF_BUSSES_IN = 4,
    parameter int                    ADDR_WIDTH      = 16,
    parameter int                    REGION_BITS     = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 16'h0000,
    parameter int                    TIMEOUT_CYCLES  = 15
) (
    input  logic                       rst,
    input  logic                       clk,
    input  logic [ADDR_WIDTH-1:0]      core_addr,
    input  logic                       core_rd,
    input  logic                       core_wr,
    input  logic [31:0]                core_wdata,
    output logic [31:0]                core_rdata,
    output logic                       core_ready,
    output logic                       core_err,
    output logic [REGION_BITS-1:0]     io_addr,
    output logic [31:0]                io_wdata,
    output logic [NR_OF_BUSSES_IN-1:0] io_rd,
    output logic [NR_OF_BUSSES_IN-1:0] io_wr,
    input  logic [NR_OF_BUSSES_IN-1:0] io_ready,
    output logic [NR_OF_BUSSES_IN-1:0] bus_sel,
    input  logic [31:0]                dmux_data
);

    localparam int         IDX_W     = ADDR_WIDTH - REGION_BITS;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_CYCLES);
    localparam logic [NR_OF_BUSSES_IN-1:0] SEL_ZERO = {NR_OF_BUSSES_IN{1'b0}};

    logic [1:0]                 state_r;
    logic [7:0]                 cnt_r;
    logic                       is_rd_r;
    logic [IDX_W-1:0]           idx_s;
    logic                       in_range_s;
    logic [NR_OF_BUSSES_IN-1:0] sel_s;
    logic                       hit_s;
    logic [7:0]                 cnt_inc_s;

    function automatic logic [NR_OF_BUSSES_IN-1:0] onehot_sel(input logic [IDX_W-1:0] idx,
                                                               input logic en);
        logic [NR_OF_BUSSES_IN-1:0] v;
        v = SEL_ZERO;
        for (int i = 0; i < NR_OF_BUSSES_IN; i++) begin
            if (en && (idx == IDX_W'(i))) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    // Address decode and ready/timeout qualification
    always_comb begin
        idx_s      = IDX_W'((core_addr - BASE_ADDR) >> REGION_BITS);
        in_range_s = (core_addr >= BASE_ADDR) && (idx_s < IDX_W'(NR_OF_BUSSES_IN));
        sel_s      = onehot_sel(idx_s, in_range_s);
        // only the selected slave's ready counts
        hit_s      = |(io_ready & bus_sel);
        cnt_inc_s  = cnt_r + 8'd1;
    end

    // Access sequencer: IDLE samples, ACCESS holds strobes, RESP pulses ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            is_rd_r    <= 1'b0;
            core_rdata <= 32'd0;
            core_ready <= 1'b0;
            core_err   <= 1'b0;
            io_addr    <= {REGION_BITS{1'b0}};
            io_wdata   <= 32'd0;
            io_rd      <= SEL_ZERO;
            io_wr      <= SEL_ZERO;
            bus_sel    <= SEL_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    core_ready <= 1'b0;
                    core_err   <= 1'b0;
                    if (core_rd && core_wr) begin
                        state_r    <= ST_RESP;
                        core_ready <= 1'b1;
                        core_err   <= 1'b1;
                        core_rdata <= 32'd0;
                    end else if (core_rd || core_wr) begin
                        if (!in_range_s) begin
                            state_r    <= ST_RESP;
                            core_ready <= 1'b1;
                            core_err   <= 1'b1;
                            if (core_rd) begin
                                core_rdata <= 32'd0;
                            end
                        end else begin
                            state_r <= ST_ACCESS;
                            io_addr <= core_addr[REGION_BITS-1:0];
                            if (core_wr) begin
                                io_wdata <= core_wdata;
                            end
                            io_rd   <= core_rd ? sel_s : SEL_ZERO;
                            io_wr   <= core_wr ? sel_s : SEL_ZERO;
                            bus_sel <= sel_s;
                            is_rd_r <= core_rd;
                            cnt_r   <= 8'd0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (hit_s) begin
                        if (is_rd_r) begin
                            core_rdata <= dmux_data;
                        end
                        io_rd      <= SEL_ZERO;
                        io_wr      <= SEL_ZERO;
                        bus_sel    <= SEL_ZERO;
                        state_r    <= ST_RESP;
                        core_ready <= 1'b1;
                        core_err   <= 1'b0;
                    end else if (cnt_inc_s >= TIMEOUT_C) begin
                        if (is_rd_r) begin
                            core_rdata <= 32'd0;
                        end
                        io_rd      <= SEL_ZERO;
                        io_wr      <= SEL_ZERO;
                        bus_sel    <= SEL_ZERO;
                        state_r    <= ST_RESP;
                        core_ready <= 1'b1;
                        core_err   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_RESP: begin
                    core_ready <= 1'b0;
                    core_err   <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    core_ready <= 1'b0;
                    core_err   <= 1'b0;
                    io_rd      <= SEL_ZERO;
                    io_wr      <= SEL_ZERO;
                    bus_sel    <= SEL_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_sel_ctrl.sv
// Scoreboard bench for io_bus_sel_ctrl: directed accesses push expected responses,
// a negedge monitor pops and compares them whenever core_ready is seen.
module tb_io_bus_sel_ctrl;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        rst, clk;
    logic [15:0] core_addr;
    logic        core_rd, core_wr;
    logic [31:0] core_wdata, core_rdata;
    logic        core_ready, core_err;
    logic [7:0]  io_addr;
    logic [31:0] io_wdata;
    logic [3:0]  io_rd, io_wr, io_ready, bus_sel;
    logic [31:0] dmux_data;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // slave model configuration
    int         s_tgt = -1;
    int         s_wait = 0;
    logic [3:0] s_extra = 4'd0;
    int         acc_cnt = 0;

    io_bus_sel_ctrl dut (
        .rst(rst), .clk(clk), .core_addr(core_addr), .core_rd(core_rd), .core_wr(core_wr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ready(core_ready),
        .core_err(core_err), .io_addr(io_addr), .io_wdata(io_wdata), .io_rd(io_rd),
        .io_wr(io_wr), .io_ready(io_ready), .bus_sel(bus_sel), .dmux_data(dmux_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: only the intended slave raises ready after s_wait wait cycles
    always @(negedge clk) begin
        logic [3:0] m;
        if ((|io_rd) || (|io_wr)) acc_cnt = acc_cnt + 1;
        else acc_cnt = 0;
        m = 4'd0;
        if (s_tgt >= 0 && acc_cnt >= 1 + s_wait) m[s_tgt] = 1'b1;
        io_ready = m | s_extra;
    end

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst && core_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_ready: got core_ready at cycle %0d, required none", cyc);
            end else begin
                e = exp_q.pop_front();
                if (core_err !== e.err || core_rdata !== e.rdata || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL response: got err=%b rdata=%h cyc=%0d, required err=%b rdata=%h cyc=%0d",
                             core_err, core_rdata, cyc, e.err, e.rdata, e.cyc);
                end
            end
        end
        if ((|io_rd) && (|io_wr)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rd_wr_exclusive: got io_rd=%b io_wr=%b, required one zero", io_rd, io_wr);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [31:0] wd, input logic [31:0] dm, input int tgt,
                             input int wt, input logic [3:0] extra, input logic exp_err,
                             input logic [31:0] exp_rdata, input int exp_strb);
        exp_t       e;
        logic [3:0] m;
        int         strb_cnt;
        bit         seen;
        m = 4'd0;
        if (tgt >= 0) m[tgt] = 1'b1;
        @(negedge clk);
        s_tgt = tgt; s_wait = wt; s_extra = extra;
        core_addr = addr; core_rd = rd; core_wr = wr; core_wdata = wd; dmux_data = dm;
        e.err = exp_err; e.rdata = exp_rdata; e.cyc = cyc + 1 + exp_strb;
        exp_q.push_back(e);
        strb_cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (core_ready) begin
                seen = 1'b1;
            end else if ((|io_rd) || (|io_wr) || (|bus_sel)) begin
                strb_cnt++;
                check("strobes", {52'd0, io_rd, io_wr, bus_sel},
                      {52'd0, (rd ? m : 4'd0), (wr ? m : 4'd0), m});
                if (strb_cnt == 1) begin
                    check("io_addr", {56'd0, io_addr}, {56'd0, addr[7:0]});
                    if (wr) check("io_wdata", {32'd0, io_wdata}, {32'd0, wd});
                end
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: got no core_ready in 40 cycles, required one");
        end
        check("strobe_cycles", 64'(strb_cnt), 64'(exp_strb));
        core_rd = 1'b0; core_wr = 1'b0;
        s_tgt = -1; s_extra = 4'd0;
    endtask

    initial begin
        rst = 1'b1;
        core_addr = 16'd0; core_rd = 1'b0; core_wr = 1'b0;
        core_wdata = 32'd0; dmux_data = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_idle", {core_rdata, core_ready, core_err, io_addr, io_rd, io_wr, bus_sel},
                  64'd0);
            check("reset_wdata", {32'd0, io_wdata}, 64'd0);
        end

        // 2: zero-wait read slave 1
        do_access(1'b1, 1'b0, 16'h0104, 32'd0, 32'hDEADBEEF, 1, 0, 4'd0, 1'b0, 32'hDEADBEEF, 1);
        // 3: write slave 3, 3 wait cycles, rdata unchanged
        do_access(1'b0, 1'b1, 16'h0310, 32'h12345678, 32'h55555555, 3, 3, 4'd0, 1'b0, 32'hDEADBEEF, 4);
        // 4: out-of-range read
        do_access(1'b1, 1'b0, 16'h0400, 32'd0, 32'h11111111, -1, 0, 4'd0, 1'b1, 32'd0, 0);
        // last byte of the last slave region
        do_access(1'b1, 1'b0, 16'h03FF, 32'd0, 32'h0BADF00D, 3, 0, 4'd0, 1'b0, 32'h0BADF00D, 1);
        // out-of-range write keeps rdata
        do_access(1'b0, 1'b1, 16'h0500, 32'hCAFE0000, 32'd0, -1, 0, 4'd0, 1'b1, 32'h0BADF00D, 0);
        // rd & wr conflict
        do_access(1'b1, 1'b1, 16'h0100, 32'd0, 32'h22222222, -1, 0, 4'd0, 1'b1, 32'd0, 0);
        do_access(1'b1, 1'b0, 16'h0004, 32'd0, 32'h77777777, 0, 0, 4'd0, 1'b0, 32'h77777777, 1);
        // 5: timeout on slave 2 with unrelated slave 0 ready
        do_access(1'b1, 1'b0, 16'h0200, 32'd0, 32'h33333333, 2, 255, 4'b0001, 1'b1, 32'd0, 15);

        // 6: async reset during a slave 0 write
        @(negedge clk);
        s_tgt = 0; s_wait = 255;
        core_addr = 16'h0008; core_wr = 1'b1; core_wdata = 32'h99999999;
        @(negedge clk);
        check("wr_before_reset", {60'd0, io_wr}, 64'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_strobes", {56'd0, io_wr, bus_sel}, 64'd0);
        repeat (2) @(negedge clk);
        core_wr = 1'b0; s_tgt = -1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        do_access(1'b1, 1'b0, 16'h0020, 32'd0, 32'hA5A50001, 0, 1, 4'd0, 1'b0, 32'hA5A50001, 2);

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
